pipe_ctrl: RTL

Pipeline sequencing controller for the 5-stage RV32I core. Generates the stage enables and flushes for the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. Covers load-use stalls, branch/jump redirect flushes, data-memory wait states with a timeout, and, optionally, EX-stage operand forwarding. Sits beside the datapath and consumes only the rd/rs/opcode fields the pipeline registers already carry.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_hazard_detect.sv | 53 +++++
 rtl/pipe_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: RV32I opcodes,
// FSM state, forwarding encodings and register-use helpers.
package pipe_ctrl_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Opcode 0 is the bubble, so it never counts as a writer.
  function automatic logic writes(input logic [6:0] op, input logic [4:0] rd);
    return (op != STORE) && (op != BRANCH) && (op != 7'd0) && (rd != 5'd0);
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op != LUI) && (op != AUIPC) && (op != JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP) || (op == STORE) || (op == BRANCH);
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational RAW hazard / forwarding select. With PIPE_FWD_EN only a
// load in EX stalls decode; otherwise any in-flight writer does.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [6:0] opcode_id_i,
  input  logic [4:0] rs1_id_i,
  input  logic [4:0] rs2_id_i,
  input  logic [6:0] opcode_ex_i,
  input  logic [4:0] rd_ex_i,
  input  logic [4:0] rs1_ex_i,
  input  logic [4:0] rs2_ex_i,
  input  logic [6:0] opcode_mem_i,
  input  logic [4:0] rd_mem_i,
  input  logic [6:0] opcode_wb_i,
  input  logic [4:0] rd_wb_i,
  output logic       hazard_o,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  logic use1, use2;
  assign use1 = uses_rs1(opcode_id_i);
  assign use2 = uses_rs2(opcode_id_i);

  function automatic logic id_reads(input logic [6:0] op, input logic [4:0] rd);
    return writes(op, rd) && ((use1 && rd == rs1_id_i) || (use2 && rd == rs2_id_i));
  endfunction

`ifdef PIPE_FWD_EN
  // Loads resolve in MEM, so their data cannot be forwarded from EX_MEM.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (writes(opcode_mem_i, rd_mem_i) && rd_mem_i == rs && opcode_mem_i != LOAD)
      return FWD_MEM;
    else if (writes(opcode_wb_i, rd_wb_i) && rd_wb_i == rs)
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  assign hazard_o = (opcode_ex_i == LOAD) && id_reads(opcode_ex_i, rd_ex_i);
  assign fwd_a_o  = fwd_sel(rs1_ex_i);
  assign fwd_b_o  = fwd_sel(rs2_ex_i);
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs1_ex_i, rs2_ex_i};
  assign hazard_o   = id_reads(opcode_ex_i, rd_ex_i) || id_reads(opcode_mem_i, rd_mem_i) ||
                      id_reads(opcode_wb_i, rd_wb_i);
  assign fwd_a_o    = FWD_RF;
  assign fwd_b_o    = FWD_RF;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencer: memory wait FSM with timeout, branch flush,
// hazard stall, stall counter. Optional forwarding via macro PIPE_FWD_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode_ID,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic [6:0]       opcode_EX,
  input  logic [4:0]       rd_EX,
  input  logic [4:0]       rs1_EX,
  input  logic [4:0]       rs2_EX,
  input  logic             take_branch_EX,
  input  logic [6:0]       opcode_MEM,
  input  logic [4:0]       rd_MEM,
  input  logic [6:0]       opcode_WB,
  input  logic [4:0]       rd_WB,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int              WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam bit              TO_EN     = (MEM_TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              hazard, timeout, mem_stall;

  pipe_hazard_detect u_hazard (
    .opcode_id_i (opcode_ID),  .rs1_id_i (rs1_ID), .rs2_id_i (rs2_ID),
    .opcode_ex_i (opcode_EX),  .rd_ex_i  (rd_EX),  .rs1_ex_i (rs1_EX), .rs2_ex_i (rs2_EX),
    .opcode_mem_i(opcode_MEM), .rd_mem_i (rd_MEM),
    .opcode_wb_i (opcode_WB),  .rd_wb_i  (rd_WB),
    .hazard_o    (hazard),     .fwd_a_o  (fwd_a),  .fwd_b_o  (fwd_b)
  );

  assign dmem_req  = ((opcode_MEM == LOAD) || (opcode_MEM == STORE)) && !mem_err_q;
  assign timeout   = TO_EN && (state_q == MEM_WAIT) && dmem_req && !dmem_ready &&
                     (wait_q == TIMEOUT_V);
  assign mem_stall = dmem_req && !dmem_ready && !timeout;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mem_stall)  state_d = MEM_WAIT;
      MEM_WAIT: if (!mem_stall) state_d = RUN;
      default:                  state_d = RUN;
    endcase
  end

  // Once memory completes (or times out) the held EX/ID pair is re-evaluated,
  // so a branch or hazard that waited behind the memory stall still applies.
  always_comb begin
    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
    {if_id_flush, id_ex_flush, mem_wb_flush}          = '0;
    if (mem_stall) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = '0;
      mem_wb_flush = 1'b1;
    end else begin
      mem_wb_flush = timeout;
      if (take_branch_EX) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (hazard) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    wait_d    = (mem_stall && TO_EN) ? wait_q + 1'b1 : '0;
    mem_err_d = mem_err_q | timeout;
    stall_d   = (!pc_en && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
    end
  end

endmodule
